// File: rtl/mskaes_rnd_source_if.sv
// Seed handshake and randomness bus between a masked-AES datapath and its
// randomness source. The source is the slave; the consumer/seeder is the master.
interface mskaes_rnd_source_if #(
    parameter int rnd_busz = 8,
    parameter int rnd_busb = 8
);
    logic                    seed_valid;
    logic                    seed_ready;
    logic [255:0]            seed;
    logic                    fresh_req;
    logic                    rnd_valid;
    logic [16*rnd_busz-1:0]  RandomZw;
    logic [16*rnd_busb-1:0]  RandomBw;
    logic                    underflow;
    logic [31:0]             adv_cnt;

    modport master (
        output seed_valid, seed, fresh_req,
        input  seed_ready, rnd_valid, RandomZw, RandomBw, underflow, adv_cnt
    );

    modport slave (
        input  seed_valid, seed, fresh_req,
        output seed_ready, rnd_valid, RandomZw, RandomBw, underflow, adv_cnt
    );
endinterface

// File: rtl/mskaes_rnd_source.sv
// Randomness source for a masked AES S-box layer: two 128-bit LFSRs (fresh masks Z,
// blinding B) advanced 128 steps per clock, with seeding, warm-up and usage counting.
module mskaes_rnd_source #(
    parameter int WARMUP_N = 8,
    parameter int rnd_busz = 8,
    parameter int rnd_busb = 8
) (
    input  logic               clk,
    input  logic               nrst,
    mskaes_rnd_source_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam state_t      LOAD_ST   = (WARMUP_N == 0) ? ST_RUN : ST_WARMUP;
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_N - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    // One advance: 128 consecutive steps of s <= {s[126:0], s127^s125^s100^s98}.
    function automatic logic [127:0] lfsr_adv128(input logic [127:0] s);
        logic [127:0] v;
        v = s;
        for (int i = 0; i < 128; i++) begin
            v = {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
        end
        return v;
    endfunction

    // The all-zero state is a fixed point of the LFSR, so it is never loaded.
    function automatic logic [127:0] seed_fix(input logic [127:0] s);
        logic [127:0] r;
        if (s == 128'h0) begin
            r = 128'h1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_seed_ready;
    logic         r_rnd_valid;
    logic         r_underflow;
    logic [127:0] r_z;
    logic [127:0] r_b;
    logic [127:0] w_z_nxt;
    logic [127:0] w_b_nxt;
    logic [7:0]   r_warm_cnt;
    logic [7:0]   w_warm_nxt;
    logic [31:0]  r_adv_cnt;
    logic [31:0]  w_cnt_nxt;
    logic         w_xfer;
    logic         w_load;
    logic         w_adv;
    logic         w_cnt_inc;

    assign w_xfer = bus.seed_valid & r_seed_ready;

    // Next-state and control decode; a seed transfer outranks fresh_req in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm_cnt;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_warm_nxt  = 8'd0;
                    w_state_nxt = LOAD_ST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                w_adv = 1'b1;
                if (r_warm_cnt == WARM_LAST) begin
                    w_warm_nxt  = 8'd0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_warm_nxt  = r_warm_cnt + 8'd1;
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_warm_nxt  = 8'd0;
                    w_state_nxt = LOAD_ST;
                end else if (bus.fresh_req) begin
                    w_adv       = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_warm_nxt  = 8'd0;
            end
        endcase
    end

    // LFSR and advance-counter datapath.
    always_comb begin
        w_z_nxt   = r_z;
        w_b_nxt   = r_b;
        w_cnt_nxt = r_adv_cnt;
        if (w_load) begin
            w_z_nxt   = seed_fix(bus.seed[127:0]);
            w_b_nxt   = seed_fix(bus.seed[255:128]);
            w_cnt_nxt = 32'h0;
        end else if (w_adv) begin
            w_z_nxt = lfsr_adv128(r_z);
            w_b_nxt = lfsr_adv128(r_b);
            if (w_cnt_inc && (r_adv_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_adv_cnt + 32'd1;
            end else begin
                w_cnt_nxt = r_adv_cnt;
            end
        end else begin
            w_z_nxt   = r_z;
            w_b_nxt   = r_b;
            w_cnt_nxt = r_adv_cnt;
        end
    end

    // State, data and registered handshake/status outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_z          <= 128'h0;
            r_b          <= 128'h0;
            r_warm_cnt   <= 8'd0;
            r_adv_cnt    <= 32'h0;
            r_seed_ready <= 1'b0;
            r_rnd_valid  <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_z          <= w_z_nxt;
            r_b          <= w_b_nxt;
            r_warm_cnt   <= w_warm_nxt;
            r_adv_cnt    <= w_cnt_nxt;
            r_seed_ready <= (w_state_nxt != ST_WARMUP);
            r_rnd_valid  <= (w_state_nxt == ST_RUN);
            r_underflow  <= r_underflow | (bus.fresh_req & ~r_rnd_valid);
        end
    end

    assign bus.seed_ready = r_seed_ready;
    assign bus.rnd_valid  = r_rnd_valid;
    assign bus.RandomZw   = r_z[16*rnd_busz-1:0];
    assign bus.RandomBw   = r_b[16*rnd_busb-1:0];
    assign bus.underflow  = r_underflow;
    assign bus.adv_cnt    = r_adv_cnt;
endmodule

// File: tb/tb_mskaes_rnd_source.sv
// Scoreboard bench: two sources (WARMUP_N=8 and WARMUP_N=0) share one stimulus stream
// and are checked against a bit-sequence reference model of the LFSR randomness source.
module tb_mskaes_rnd_source;
    typedef struct {
        logic         sr;
        logic         rv;
        logic         uf;
        logic [31:0]  cnt;
        logic [127:0] z;
        logic [127:0] b;
    } exp_t;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_RUN  = 2;

    logic         clk;
    logic         nrst;
    logic         sv;
    logic [255:0] sd;
    logic         fr;

    int vectors     = 0;
    int miscompares = 0;

    exp_t q0[$];
    exp_t q1[$];

    int           wn[2] = '{8, 0};
    int           m_mode[2];
    int           m_wrem[2];
    logic         m_sr[2];
    logic         m_rv[2];
    logic         m_uf[2];
    logic [31:0]  m_cnt[2];
    logic [127:0] m_z[2];
    logic [127:0] m_b[2];

    mskaes_rnd_source_if #(.rnd_busz(8), .rnd_busb(8)) if0 ();
    mskaes_rnd_source_if #(.rnd_busz(8), .rnd_busb(8)) if1 ();

    assign if0.seed_valid = sv;
    assign if0.seed       = sd;
    assign if0.fresh_req  = fr;
    assign if1.seed_valid = sv;
    assign if1.seed       = sd;
    assign if1.fresh_req  = fr;

    mskaes_rnd_source #(.WARMUP_N(8), .rnd_busz(8), .rnd_busb(8)) u0 (
        .clk(clk), .nrst(nrst), .bus(if0)
    );
    mskaes_rnd_source #(.WARMUP_N(0), .rnd_busz(8), .rnd_busb(8)) u1 (
        .clk(clk), .nrst(nrst), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference advance: state bit 127-j is sequence element x[t+j], and the
    // sequence obeys x[n+128] = x[n] ^ x[n+2] ^ x[n+27] ^ x[n+29].
    function automatic logic [127:0] ref_adv(input logic [127:0] s);
        logic         x[256];
        logic [127:0] r;
        for (int j = 0; j < 128; j++) x[j] = s[127-j];
        for (int n = 0; n < 128; n++) x[n+128] = x[n] ^ x[n+2] ^ x[n+27] ^ x[n+29];
        for (int j = 0; j < 128; j++) r[127-j] = x[128+j];
        return r;
    endfunction

    function automatic logic [127:0] ref_seed(input logic [127:0] s);
        return (s == 128'h0) ? 128'h1 : s;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k] = M_IDLE;
        m_wrem[k] = 0;
        m_sr[k]   = 1'b0;
        m_rv[k]   = 1'b0;
        m_uf[k]   = 1'b0;
        m_cnt[k]  = 32'h0;
        m_z[k]    = 128'h0;
        m_b[k]    = 128'h0;
    endtask

    task automatic model_step(input int k);
        logic xfer;
        if (!nrst) begin
            model_reset(k);
            return;
        end
        xfer = sv && m_sr[k];
        if (fr && !m_rv[k]) m_uf[k] = 1'b1;
        if (m_mode[k] == M_WARM) begin
            m_z[k]    = ref_adv(m_z[k]);
            m_b[k]    = ref_adv(m_b[k]);
            m_wrem[k] = m_wrem[k] - 1;
            if (m_wrem[k] == 0) m_mode[k] = M_RUN;
        end else if (xfer) begin
            m_z[k]    = ref_seed(sd[127:0]);
            m_b[k]    = ref_seed(sd[255:128]);
            m_cnt[k]  = 32'h0;
            m_wrem[k] = wn[k];
            m_mode[k] = (wn[k] == 0) ? M_RUN : M_WARM;
        end else if (m_mode[k] == M_RUN && fr) begin
            m_z[k] = ref_adv(m_z[k]);
            m_b[k] = ref_adv(m_b[k]);
            if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
        end
        m_sr[k] = (m_mode[k] != M_WARM);
        m_rv[k] = (m_mode[k] == M_RUN);
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.sr  = m_sr[k];
        e.rv  = m_rv[k];
        e.uf  = m_uf[k];
        e.cnt = m_cnt[k];
        e.z   = m_z[k];
        e.b   = m_b[k];
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        #1;
    endtask

    task automatic check(input int k, input exp_t e, input exp_t a);
        vectors++;
        if (a.sr !== e.sr || a.rv !== e.rv || a.uf !== e.uf || a.cnt !== e.cnt ||
            a.z !== e.z || a.b !== e.b) begin
            miscompares++;
            $display("FAIL scoreboard dut%0d t=%0t: got rdy=%b vld=%b uf=%b cnt=%h zw=%h bw=%h, required rdy=%b vld=%b uf=%b cnt=%h zw=%h bw=%h",
                     k, $time, a.sr, a.rv, a.uf, a.cnt, a.z, a.b,
                     e.sr, e.rv, e.uf, e.cnt, e.z, e.b);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.sr = 1'b0; e.rv = 1'b0; e.uf = 1'b0;
        e.cnt = 32'h0; e.z = 128'h0; e.b = 128'h0;
        return e;
    endfunction

    function automatic exp_t act0();
        exp_t a;
        a.sr = if0.seed_ready; a.rv = if0.rnd_valid; a.uf = if0.underflow;
        a.cnt = if0.adv_cnt; a.z = if0.RandomZw; a.b = if0.RandomBw;
        return a;
    endfunction

    function automatic exp_t act1();
        exp_t a;
        a.sr = if1.seed_ready; a.rv = if1.rnd_valid; a.uf = if1.underflow;
        a.cnt = if1.adv_cnt; a.z = if1.RandomZw; a.b = if1.RandomBw;
        return a;
    endfunction

    // Monitor: compare each presented output cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, e, act0());
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, e, act1());
        end
    end

    initial begin
        int r;
        nrst = 1'b0;
        sv   = 1'b0;
        sd   = 256'h0;
        fr   = 1'b0;
        model_reset(0);
        model_reset(1);

        repeat (3) cycle();
        nrst = 1'b1;
        repeat (2) cycle();

        // Request in IDLE must latch underflow.
        fr = 1'b1;
        cycle();
        fr = 1'b0;
        cycle();

        // Z=5, B=0: B is substituted by 1; the WARMUP_N=0 source is valid next cycle.
        sv = 1'b1;
        sd = {128'h0, 128'h5};
        cycle();
        sv = 1'b0;
        sd = 256'h0;
        repeat (10) cycle();

        // Three isolated requests between idle cycles.
        for (int p = 0; p < 3; p++) begin
            repeat (3) cycle();
            fr = 1'b1;
            cycle();
            fr = 1'b0;
        end
        repeat (2) cycle();

        // Reseed together with a request: reseed wins.
        sv = 1'b1;
        fr = 1'b1;
        sd = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        cycle();
        sv = 1'b0;
        fr = 1'b0;
        repeat (10) cycle();

        // Randomized requests and occasional reseeds, some with all-zero halves.
        for (int i = 0; i < 400; i++) begin
            fr = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 39) == 0);
            sd = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            r = $urandom_range(0, 3);
            if (r == 0) sd[255:128] = 128'h0;
            if (r == 1) sd[127:0] = 128'h0;
            cycle();
        end
        sv = 1'b0;
        fr = 1'b0;
        repeat (10) cycle();

        // Saturation: preload the counter just below its ceiling, then two requests.
        @(negedge clk);
        #1;
        force u0.r_adv_cnt = 32'hFFFF_FFFE;
        force u1.r_adv_cnt = 32'hFFFF_FFFE;
        #1;
        release u0.r_adv_cnt;
        release u1.r_adv_cnt;
        m_cnt[0] = 32'hFFFF_FFFE;
        m_cnt[1] = 32'hFFFF_FFFE;
        fr = 1'b1;
        repeat (2) cycle();
        fr = 1'b0;
        repeat (2) cycle();

        // Asynchronous reset mid-RUN: outputs clear before the next clock edge.
        fr = 1'b1;
        cycle();
        fr = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check(0, zero_exp(), act0());
        check(1, zero_exp(), act1());
        q0.delete();
        q1.delete();
        model_reset(0);
        model_reset(1);
        repeat (2) cycle();
        nrst = 1'b1;
        repeat (3) cycle();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
